bcd_stopwatch: RTL and testbench

- Consumes the slow square-wave output of the design's clock divider (nominally 1 Hz, generated from the same system clock).
- Synchronizes that wave and detects its rising edges to form a one-cycle tick.
- Counts ticks as a stopwatch in BCD minutes:seconds for the 7-segment display path.
- Controlled by start/stop/clear command pulses from the button front end.

---
 rtl/bcd_stopwatch.sv | 183 ++++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: BCD minutes:seconds stopwatch driven by the divided
// square wave from the clock divider. The wave is resynchronised, its
// rising edges become one-cycle ticks, and the ticks advance an
// MM:SS BCD count under start/stop/clear command control.
//
// Optional lap capture is compiled in with `define BCD_STOPWATCH_LAP_EN.
// Without it the lap input is absent and lap_time is tied to zero.
module bcd_stopwatch #(
  parameter int MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        tick_out,
  output logic        wrap,
  output logic [15:0] lap_time
);

  // Highest minutes value split into its BCD digits.
  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        tick;
  logic        count_en;
  logic [15:0] digits;
  logic [16:0] inc;

  // One BCD step of the MM:SS vector. Bit 16 flags the roll from
  // MAX_MIN:59 back to 00:00. The minutes compare uses >= so that a
  // corrupted value still collapses to 00:00 rather than running away.
  function automatic logic [16:0] bcd_inc(input logic [15:0] d);
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic       w;
    mt = d[15:12];
    mo = d[11:8];
    st = d[7:4];
    so = d[3:0];
    w  = 1'b0;
    if (so < 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (st < 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if ((mt > MAX_TENS) || ((mt == MAX_TENS) && (mo >= MAX_ONES))) begin
          mt = 4'd0;
          mo = 4'd0;
          w  = 1'b1;
        end else if (mo < 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          mt = mt + 4'd1;
        end
      end
    end
    return {w, mt, mo, st, so};
  endfunction

  // Three-flop resynchroniser; s2/s3 form the rising-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Tick is a function of flops only, so tick_out has no input path.
  assign tick     = s2 & ~s3;
  assign tick_out = tick;

  // The count advances only from RUN; clear always overrides.
  assign count_en = (state == RUN) && tick && !clear;
  assign inc      = bcd_inc(digits);

  // Command FSM: clear beats stop beats start; running mirrors RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // BCD count register and the one-cycle wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= 16'h0000;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        digits <= 16'h0000;
      end else if (count_en) begin
        digits <= inc[15:0];
        wrap   <= inc[16];
      end
    end
  end

  assign min_tens = digits[15:12];
  assign min_ones = digits[11:8];
  assign sec_tens = digits[7:4];
  assign sec_ones = digits[3:0];

`ifdef BCD_STOPWATCH_LAP_EN
  logic [15:0] lap_q;

  // Lap snapshot takes the pre-increment digits; ignored while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= 16'h0000;
    end else if (clear) begin
      lap_q <= 16'h0000;
    end else if (lap && (state != IDLE)) begin
      lap_q <= digits;
    end
  end

  assign lap_time = lap_q;
`else
  assign lap_time = 16'h0000;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: a cycle-level reference model
// built on an integer seconds count feeds a scoreboard queue, and a
// monitor pops an expectation each time the DUT shows tick_out.
module tb_bcd_stopwatch;

  localparam int MAX_MIN = 59;
`ifdef BCD_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [3:0]  sec_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  min_ones;
  logic [3:0]  min_tens;
  logic        running;
  logic        tick_out;
  logic        wrap;
  logic [15:0] lap_time;
  logic [15:0] dig_o;

  assign dig_o = {min_tens, min_ones, sec_tens, sec_ones};

  bcd_stopwatch #(.MAX_MIN(MAX_MIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap      (lap),
`endif
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .tick_out (tick_out),
    .wrap     (wrap),
    .lap_time (lap_time)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [15:0] dig;
    logic        run;
    logic        wr;
    logic [15:0] lp;
  } rec_t;

  rec_t        sbq[$];
  int          due_q[$];
  int          m_total = 0;
  int          m_st = 0;         // 0 idle, 1 run, 2 pause
  logic [15:0] m_lap = 16'h0000;
  logic        prev_s = 1'b0;
  int          edge_cnt = 0;
  int          exp_wraps = 0;
  int          obs_wraps = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [15:0] to_bcd(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed seconds as an integer, ticks due two edges
  // after the first high sample of each tick_in rise.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_total = 0;
        m_st    = 0;
        m_lap   = 16'h0000;
        prev_s  = 1'b0;
        due_q.delete();
      end else begin : model_step
        bit          tk;
        bit          wr;
        logic [15:0] cur;
        edge_cnt++;
        tk = (due_q.size() > 0) && (due_q[0] == edge_cnt);
        if (tk) void'(due_q.pop_front());
        if (tick_in && !prev_s) due_q.push_back(edge_cnt + 2);
        prev_s = tick_in;
        cur = to_bcd(m_total);
        wr  = 1'b0;
        if (clear) begin
          m_total = 0;
          m_lap   = 16'h0000;
        end else begin
          if (LAP_EN && lap && m_st != 0) m_lap = cur;
          if (m_st == 1 && tk) begin
            m_total++;
            if (m_total == (MAX_MIN + 1) * 60) begin
              m_total = 0;
              wr = 1'b1;
              exp_wraps++;
            end
          end
        end
        if (clear) m_st = 0;
        else if (stop) begin
          if (m_st == 1) m_st = 2;
        end else if (start && m_st != 1) m_st = 1;
        if (tk) sbq.push_back('{edge_cnt, to_bcd(m_total), (m_st == 1), wr, m_lap});
      end
    end
  end

  // Monitor: running every cycle; on tick_out, pop and check the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("running", {31'd0, running}, {31'd0, (m_st == 1)});
        if (wrap === 1'b1) obs_wraps++;
        if (tick_out === 1'b1) begin
          @(posedge clk);
          #1;
          if (sbq.size() == 0) begin
            chk("tick_unexpected", 32'd1, 32'd0);
          end else begin : pop_blk
            rec_t r;
            r = sbq.pop_front();
            chk("tick_latency", edge_cnt, r.edge_no);
            chk("digits", {16'd0, dig_o}, {16'd0, r.dig});
            chk("running_tick", {31'd0, running}, {31'd0, r.run});
            chk("wrap", {31'd0, wrap}, {31'd0, r.wr});
            chk("lap_time", {16'd0, lap_time}, {16'd0, r.lp});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_fast();
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
  endtask

  // Tick whose counting edge coincides with the given commands.
  task automatic tick_cmd(input bit c_start, input bit c_stop, input bit c_clear, input bit c_lap);
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
    @(negedge clk); start = c_start; stop = c_stop; clear = c_clear; lap = c_lap;
    @(negedge clk); start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic cmd(input bit c_start, input bit c_stop, input bit c_clear, input bit c_lap);
    @(negedge clk); start = c_start; stop = c_stop; clear = c_clear; lap = c_lap;
    @(negedge clk); start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digits"}, {16'd0, dig_o}, 32'd0);
    chk({tag, "_running"}, {31'd0, running}, 32'd0);
    chk({tag, "_tick_out"}, {31'd0, tick_out}, 32'd0);
    chk({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
    chk({tag, "_lap"}, {16'd0, lap_time}, 32'd0);
  endtask

  initial begin
    idle(3);
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Count to 00:07, then async reset mid-cycle.
    cmd(1, 0, 0, 0);
    repeat (7) tick_cmd(0, 0, 0, 0);
    idle(4);
    chk("pre_reset_digits", {16'd0, dig_o}, 32'h0007);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;

    // 60 ticks -> 01:00.
    cmd(1, 0, 0, 0);
    repeat (60) tick_fast();
    idle(4);
    chk("carry_0100", {16'd0, dig_o}, 32'h0100);

    // start+stop with a tick in RUN: tick counts, then paused.
    tick_cmd(1, 1, 0, 0);
    repeat (3) tick_fast();
    idle(4);
    chk("startstop_digits", {16'd0, dig_o}, 32'h0101);
    chk("startstop_run", {31'd0, running}, 32'd0);

    // Clear coincident with a tick at 00:05.
    cmd(0, 0, 1, 0);
    cmd(1, 0, 0, 0);
    repeat (5) tick_fast();
    tick_cmd(0, 0, 1, 0);
    idle(4);
    chk("clear_tick_digits", {16'd0, dig_o}, 32'h0000);
    chk("clear_tick_run", {31'd0, running}, 32'd0);

    // Stop coincident with a tick at 00:10, then resume.
    cmd(1, 0, 0, 0);
    repeat (10) tick_fast();
    tick_cmd(0, 1, 0, 0);
    idle(4);
    chk("stop_tick_digits", {16'd0, dig_o}, 32'h0011);
    chk("stop_tick_run", {31'd0, running}, 32'd0);
    cmd(1, 0, 0, 0);
    tick_fast();
    idle(4);
    chk("resume_digits", {16'd0, dig_o}, 32'h0012);

    // Lap at 02:34, then a lap on a counting edge.
    cmd(0, 0, 1, 0);
    cmd(1, 0, 0, 0);
    repeat (154) tick_fast();
    idle(4);
    cmd(0, 0, 0, 1);
    chk("lap_0234", {16'd0, lap_time}, LAP_EN ? 32'h0234 : 32'h0000);
    tick_cmd(0, 0, 0, 1);

    // Wrap from 59:58.
    cmd(0, 0, 1, 0);
    cmd(1, 0, 0, 0);
    repeat (3598) tick_fast();
    idle(4);
    chk("pre_wrap_digits", {16'd0, dig_o}, 32'h5958);
    repeat (2) tick_fast();
    idle(4);
    chk("post_wrap_digits", {16'd0, dig_o}, 32'h0000);
    chk("post_wrap_run", {31'd0, running}, 32'd1);
    chk("wrap_count_directed", obs_wraps, 32'd1);

    // Randomised mix of ticks and commands.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) tick_fast();
      else if (r <= 6)
        tick_cmd($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      else if (r <= 8)
        cmd($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      else idle($urandom_range(1, 3));
    end

    idle(8);
    chk("sb_leftover", sbq.size(), 32'd0);
    chk("ticks_pending", due_q.size(), 32'd0);
    chk("wrap_count", obs_wraps, exp_wraps);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
